// File: rtl/stl_rr_scatter_pkg.sv
// ============================================================================
// Module   : stl_pkg
// Purpose  : Shared definitions for the round-robin scatter block: search
//            direction encodings, the lane-index type and a width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stl_pkg;

  // Search direction encodings for the TYPE parameter.
  localparam int STL_DIR_ASC  = 0;
  localparam int STL_DIR_DESC = 1;

  // Widest lane index supported (REQ_N up to 64). Modules narrow it to
  // lane_w(REQ_N) bits for their own pointer and select signals.
  localparam int LANE_W_MAX = 6;
  typedef logic [LANE_W_MAX-1:0] lane_idx_t;

  // Number of bits needed to index n lanes (never less than one).
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stl_rr_scatter_if.sv
// ============================================================================
// Module   : stl_rr_scatter_if
// Purpose  : Input beat handshake plus per-lane output handshake bundle.
// Ports    : in_vld_i / in_rdy_o / in_data_i   - single input stream
//            out_vld_o / out_rdy_i / out_data_o - REQ_N lanes, data packed
//                                                 lane-major (lane i at
//                                                 [i*DATA_W +: DATA_W])
//            modport slave  - the scatter block
//            modport master - the producer / consumers driving it
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stl_rr_scatter_if #(
  parameter int REQ_N  = 16,
  parameter int DATA_W = 32
);

  logic                    in_vld_i;
  logic                    in_rdy_o;
  logic [DATA_W-1:0]       in_data_i;
  logic [REQ_N-1:0]        out_vld_o;
  logic [REQ_N-1:0]        out_rdy_i;
  logic [REQ_N*DATA_W-1:0] out_data_o;

  modport slave (
    input  in_vld_i, in_data_i, out_rdy_i,
    output in_rdy_o, out_vld_o, out_data_o
  );

  modport master (
    output in_vld_i, in_data_i, out_rdy_i,
    input  in_rdy_o, out_vld_o, out_data_o
  );

endinterface

`default_nettype wire

// File: rtl/stl_rr_scatter_find.sv
// ============================================================================
// Module   : stl_rr_find
// Purpose  : Combinational rotated find-first-free. Starting at ptr
//            (inclusive) and walking ascending (TYPE 0) or descending
//            (TYPE 1) with wrap modulo REQ_N, returns the first lane whose
//            free bit is set. Output is don't-care when no lane is free.
// Ports    : free - per-lane free flags
//            ptr  - search start index
//            sel  - selected lane index
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stl_rr_find
  import stl_pkg::*;
#(
  parameter int REQ_N = 16,
  parameter int TYPE  = STL_DIR_ASC
) (
  input  logic [REQ_N-1:0]         free,
  input  logic [lane_w(REQ_N)-1:0] ptr,
  output logic [lane_w(REQ_N)-1:0] sel
);

  localparam int LW = lane_w(REQ_N);

  // Walk offsets from farthest to nearest so the nearest free lane is the
  // last one written. Wrap is done by a single add/subtract of REQ_N, which
  // is exact for any lane count, power of two or not.
  always_comb begin
    int              idx;
    logic [LW-1:0]   cand;
    idx  = 0;
    cand = '0;
    sel  = '0;
    for (int k = REQ_N - 1; k >= 0; k--) begin
      if (TYPE == STL_DIR_DESC) begin
        idx = int'(ptr) - k;
        if (idx < 0) idx = idx + REQ_N;
      end else begin
        idx = int'(ptr) + k;
        if (idx >= REQ_N) idx = idx - REQ_N;
      end
      cand = LW'(idx);
      if (free[cand]) sel = cand;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stl_rr_scatter.sv
// ============================================================================
// Module   : stl_rr_scatter
// Purpose  : Round-robin scatter of a single input stream onto REQ_N output
//            lanes. Each lane is a one-entry register; a beat goes to the
//            first free lane found from the rotating pointer.
// Ports    : clk, rst     - clock, asynchronous active-high reset
//            bus (slave)  - input beat handshake and per-lane outputs
//            ptr_o        - current search start pointer
//            last_lane_o  - lane loaded by the latest accepted beat
//            cnt_o        - saturating accepted-beat count, present only
//                           when STL_RR_SCATTER_CNT_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stl_rr_scatter
  import stl_pkg::*;
#(
  parameter int REQ_N  = 16,
  parameter int DATA_W = 32,
  parameter int TYPE   = STL_DIR_ASC
) (
  input  logic                     clk,
  input  logic                     rst,
  stl_rr_scatter_if.slave          bus,
  output logic [lane_w(REQ_N)-1:0] ptr_o,
  output logic [lane_w(REQ_N)-1:0] last_lane_o
`ifdef STL_RR_SCATTER_CNT_EN
  ,
  output logic [15:0]              cnt_o
`endif
);

  localparam int            LW         = lane_w(REQ_N);
  localparam logic [LW-1:0] c_last_idx = LW'(REQ_N - 1);

  logic [REQ_N-1:0] r_vld;
  logic [LW-1:0]    r_ptr;
  logic [LW-1:0]    r_last;

  logic [REQ_N-1:0] w_free;
  logic [REQ_N-1:0] w_load;
  logic             w_xfer;
  logic [LW-1:0]    w_sel;
  logic [LW-1:0]    w_ptr_nxt;

  // A lane is free if empty or being drained this cycle, so a full lane
  // with its consumer ready can be refilled back-to-back.
  assign w_free       = ~r_vld | bus.out_rdy_i;
  assign bus.in_rdy_o = |w_free;
  assign w_xfer       = bus.in_vld_i & bus.in_rdy_o;

  stl_rr_find #(
    .REQ_N (REQ_N),
    .TYPE  (TYPE)
  ) u_find (
    .free (w_free),
    .ptr  (r_ptr),
    .sel  (w_sel)
  );

  always_comb begin
    w_load = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (w_xfer && (w_sel == LW'(i))) w_load[i] = 1'b1;
    end
  end

  // Pointer moves one past the selected lane in the search direction,
  // wrapping explicitly at the ends of the lane range.
  always_comb begin
    if (TYPE == STL_DIR_DESC) begin
      w_ptr_nxt = (w_sel == '0) ? c_last_idx : (w_sel - LW'(1));
    end else begin
      w_ptr_nxt = (w_sel == c_last_idx) ? '0 : (w_sel + LW'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_ptr  <= '0;
      r_last <= '0;
    end else begin
      // Load wins over drain, giving the no-bubble refill.
      r_vld <= (r_vld & ~bus.out_rdy_i) | w_load;
      if (w_xfer) begin
        r_ptr  <= w_ptr_nxt;
        r_last <= w_sel;
      end
    end
  end

  // Lane payload registers carry no reset; data is only meaningful with valid.
  for (genvar g = 0; g < REQ_N; g++) begin : g_lane
    logic [DATA_W-1:0] r_data;
    always_ff @(posedge clk) begin
      if (w_load[g]) r_data <= bus.in_data_i;
    end
    assign bus.out_data_o[g*DATA_W +: DATA_W] = r_data;
  end

  assign bus.out_vld_o = r_vld;
  assign ptr_o         = r_ptr;
  assign last_lane_o   = r_last;

`ifdef STL_RR_SCATTER_CNT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_xfer && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
  assign cnt_o = r_cnt;
`else
  // Beat counter is not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_stl_rr_scatter.sv
// ============================================================================
// Module   : tb_stl_rr_scatter
// Purpose  : Self-checking bench for stl_rr_scatter. Three instances:
//            A (REQ_N=4, ascending), B (REQ_N=4, descending) and
//            C (REQ_N=5, ascending). Expected lane/data/pointer for every
//            accepted beat is queued when the beat is driven and compared
//            after the edge. Counter checks apply when
//            STL_RR_SCATTER_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stl_rr_scatter;
  import stl_pkg::*;

  logic clk;
  logic rst;

  stl_rr_scatter_if #(.REQ_N(4), .DATA_W(32)) if_a ();
  stl_rr_scatter_if #(.REQ_N(4), .DATA_W(32)) if_b ();
  stl_rr_scatter_if #(.REQ_N(5), .DATA_W(32)) if_c ();

  logic [1:0] ptr_a, last_a, ptr_b, last_b;
  logic [2:0] ptr_c, last_c;
`ifdef STL_RR_SCATTER_CNT_EN
  logic [15:0] cnt_a, cnt_b, cnt_c;
`endif

  stl_rr_scatter #(.REQ_N(4), .DATA_W(32), .TYPE(STL_DIR_ASC)) u_dut_a (
    .clk (clk), .rst (rst), .bus (if_a), .ptr_o (ptr_a), .last_lane_o (last_a)
`ifdef STL_RR_SCATTER_CNT_EN
    , .cnt_o (cnt_a)
`endif
  );

  stl_rr_scatter #(.REQ_N(4), .DATA_W(32), .TYPE(STL_DIR_DESC)) u_dut_b (
    .clk (clk), .rst (rst), .bus (if_b), .ptr_o (ptr_b), .last_lane_o (last_b)
`ifdef STL_RR_SCATTER_CNT_EN
    , .cnt_o (cnt_b)
`endif
  );

  stl_rr_scatter #(.REQ_N(5), .DATA_W(32), .TYPE(STL_DIR_ASC)) u_dut_c (
    .clk (clk), .rst (rst), .bus (if_c), .ptr_o (ptr_c), .last_lane_o (last_c)
`ifdef STL_RR_SCATTER_CNT_EN
    , .cnt_o (cnt_c)
`endif
  );

  // Stimulus, one set per instance; payload is shared.
  logic        vld [3];
  logic [4:0]  rdy [3];
  logic [31:0] din;

  assign if_a.in_vld_i  = vld[0];
  assign if_a.in_data_i = din;
  assign if_a.out_rdy_i = rdy[0][3:0];
  assign if_b.in_vld_i  = vld[1];
  assign if_b.in_data_i = din;
  assign if_b.out_rdy_i = rdy[1][3:0];
  assign if_c.in_vld_i  = vld[2];
  assign if_c.in_data_i = din;
  assign if_c.out_rdy_i = rdy[2];

  // Uniform view of all three instances' outputs.
  logic        irdy [3];
  logic [4:0]  ovld [3];
  logic [31:0] odat [3][5];
  int          optr [3];
  int          olst [3];

  always_comb begin
    irdy[0] = if_a.in_rdy_o;
    irdy[1] = if_b.in_rdy_o;
    irdy[2] = if_c.in_rdy_o;
    ovld[0] = {1'b0, if_a.out_vld_o};
    ovld[1] = {1'b0, if_b.out_vld_o};
    ovld[2] = if_c.out_vld_o;
    for (int d = 0; d < 3; d++) begin
      for (int l = 0; l < 5; l++) odat[d][l] = '0;
    end
    for (int l = 0; l < 4; l++) begin
      odat[0][l] = if_a.out_data_o[l*32 +: 32];
      odat[1][l] = if_b.out_data_o[l*32 +: 32];
    end
    for (int l = 0; l < 5; l++) odat[2][l] = if_c.out_data_o[l*32 +: 32];
    optr[0] = int'(ptr_a);
    optr[1] = int'(ptr_b);
    optr[2] = int'(ptr_c);
    olst[0] = int'(last_a);
    olst[1] = int'(last_b);
    olst[2] = int'(last_c);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          dut;
    int          lane;
    logic [31:0] data;
    int          ptr;
  } exp_t;

  exp_t sbq[$];

  // Offer one beat to instance d for one cycle. If acceptance is expected,
  // the landing lane, payload and following pointer are queued and checked
  // once the edge has passed.
  task automatic beat(input int d, input logic [31:0] v, input bit acc,
                      input int lane, input int p);
    exp_t e;
    din    = v;
    vld[d] = 1'b1;
    #1;
    check_eq("in_rdy", {31'd0, irdy[d]}, {31'd0, acc});
    if (acc) sbq.push_back('{d, lane, v, p});
    @(posedge clk);
    #1;
    vld[d] = 1'b0;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check_eq("lane_vld", {31'd0, ovld[e.dut][e.lane]}, 32'd1);
      check_eq("lane_data", odat[e.dut][e.lane], e.data);
      check_eq("last_lane", olst[e.dut], e.lane);
      check_eq("ptr", optr[e.dut], e.ptr);
    end
  endtask

  initial begin
    rst = 1'b0;
    din = '0;
    for (int d = 0; d < 3; d++) begin
      vld[d] = 1'b0;
      rdy[d] = '0;
    end

    // Reset takes effect before any clock edge.
    #3 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check_eq("rst_vld", {27'd0, ovld[d]}, 32'd0);
      check_eq("rst_ptr", optr[d], 0);
      check_eq("rst_last", olst[d], 0);
    end
`ifdef STL_RR_SCATTER_CNT_EN
    check_eq("rst_cnt", {16'd0, cnt_a}, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check_eq("rdy_after_rst", {31'd0, irdy[d]}, 32'd1);

    // A: all consumers ready, four beats fill lanes 0..3 in order.
    rdy[0] = 5'b01111;
    for (int i = 0; i < 4; i++) beat(0, 32'hA + i, 1'b1, i, (i + 1) % 4);
    @(posedge clk);
    #1;
    check_eq("a_drained", {27'd0, ovld[0]}, 32'd0);
    check_eq("a_ptr_hold", optr[0], 0);

    // B: descending search, wrap from 0 down to 3.
    rdy[1] = 5'b01111;
    beat(1, 32'h11, 1'b1, 0, 3);
    beat(1, 32'h22, 1'b1, 3, 2);

    // A: consumers stalled, four beats fill every lane, fifth is refused.
    rdy[0] = '0;
    for (int i = 0; i < 4; i++) beat(0, 32'h100 + i, 1'b1, i, (i + 1) % 4);
    beat(0, 32'h104, 1'b0, 0, 0);
    check_eq("full_ptr_hold", optr[0], 0);
    check_eq("full_last_hold", olst[0], 3);
    check_eq("full_vld", {27'd0, ovld[0]}, 32'hF);
    check_eq("full_data_hold", odat[0][0], 32'h100);
    // Lane 2 drains and reloads in the same cycle.
    rdy[0] = 5'b00100;
    beat(0, 32'h105, 1'b1, 2, 3);
    check_eq("reload_other_hold", odat[0][1], 32'h101);
    @(posedge clk);
    #1;
    check_eq("lane2_drained", {27'd0, ovld[0]}, 32'hB);
    rdy[0] = '0;

    // Reset mid-stream with three lanes valid and a non-zero pointer.
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_vld", {27'd0, ovld[0]}, 32'd0);
    check_eq("mid_rst_ptr", optr[0], 0);
    check_eq("mid_rst_last", olst[0], 0);
`ifdef STL_RR_SCATTER_CNT_EN
    check_eq("mid_rst_cnt", {16'd0, cnt_a}, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("rdy_after_mid_rst", {31'd0, irdy[0]}, 32'd1);

    // C: REQ_N=5 with lane 4 stuck full. Walk the pointer round to 4, then
    // the next beat must wrap to lane 0.
    rdy[2] = 5'b01111;
    for (int i = 0; i < 9; i++) beat(2, 32'h200 + i, 1'b1, i % 5, ((i % 5) + 1) % 5);
    check_eq("c_ptr_at_4", optr[2], 4);
    beat(2, 32'h209, 1'b1, 0, 1);
    check_eq("c_lane4_vld", {31'd0, ovld[2][4]}, 32'd1);
    check_eq("c_lane4_data", odat[2][4], 32'h204);

`ifdef STL_RR_SCATTER_CNT_EN
    // Counter saturation after 70000 back-to-back beats on A.
    rdy[0] = 5'b01111;
    din    = 32'h5A5A;
    vld[0] = 1'b1;
    repeat (70000) @(posedge clk);
    #1 vld[0] = 1'b0;
    check_eq("cnt_sat", {16'd0, cnt_a}, 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
